// File: rtl/segre_pkg.sv
// Shared types for the segre core: word size, memop data types and the
// memory arbiter's state/owner enums plus store-lane helpers.
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'b00,
    ARB_BUSY     = 2'b01,
    ARB_MISALIGN = 2'b10
  } mem_arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_e;

  function automatic logic is_misaligned(input memop_data_type_e t, input logic [1:0] a);
    case (t)
      HALF:    return a[0];
      WORD:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input memop_data_type_e t, input logic [1:0] a);
    case (t)
      BYTE:    return 4'b0001 << a;
      HALF:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store value into every lane; byte enables pick the live one.
  function automatic logic [WORD_SIZE-1:0] store_data(input memop_data_type_e t,
                                                      input logic [WORD_SIZE-1:0] w);
    case (t)
      BYTE:    return {4{w[7:0]}};
      HALF:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/segre_load_align.sv
// Load-lane extraction: picks the byte/half addressed by off from the raw
// memory word and sign- or zero-extends it; WORD passes through.
module segre_load_align
  import segre_pkg::*;
(
  input  logic [WORD_SIZE-1:0] raw_i,
  input  logic [1:0]           off_i,
  input  memop_data_type_e     type_i,
  input  logic                 sign_ext_i,
  output logic [WORD_SIZE-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = raw_i[{off_i, 3'b000} +: 8];
    h      = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    data_o = raw_i;
    case (type_i)
      BYTE:    data_o = {{24{sign_ext_i & b[7]}}, b};
      HALF:    data_o = {{16{sign_ext_i & h[15]}}, h};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Single-port memory arbiter between fetch and the data-memory stage: one
// outstanding access, DM priority with IF anti-starvation, lane placement.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 if_req_i,
  input  logic [WORD_SIZE-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [WORD_SIZE-1:0] if_rdata_o,
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  memop_data_type_e     dm_type_i,
  input  logic                 dm_sign_ext_i,
  input  logic [WORD_SIZE-1:0] dm_addr_i,
  input  logic [WORD_SIZE-1:0] dm_wdata_i,
  output logic                 dm_gnt_o,
  output logic                 dm_rvalid_o,
  output logic [WORD_SIZE-1:0] dm_rdata_o,
  output logic                 dm_misalign_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_SIZE-1:0] mem_rdata_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  mem_arb_state_e   state_q, state_d;
  arb_owner_e       owner_q;
  memop_data_type_e type_q;
  logic [1:0]       off_q;
  logic             sext_q, we_q;
  logic [3:0]       starve_q;
  logic             if_win, idle, dm_mis, done;
  logic [WORD_SIZE-1:0] load_data;

  // DM has priority unless IF has lost STARVE_LIMIT times in a row.
  assign idle     = state_q == ARB_IDLE;
  assign if_win   = if_req_i && (!dm_req_i || starve_q == LIMIT);
  assign if_gnt_o = idle && if_win;
  assign dm_gnt_o = idle && dm_req_i && !if_win;
  assign dm_mis   = is_misaligned(dm_type_i, dm_addr_i[1:0]);
  assign done     = state_q == ARB_BUSY && mem_rvalid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (if_gnt_o)      state_d = ARB_BUSY;
        else if (dm_gnt_o) state_d = dm_mis ? ARB_MISALIGN : ARB_BUSY;
      end
      ARB_BUSY:     if (mem_rvalid_i) state_d = ARB_IDLE;
      ARB_MISALIGN: state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_IF;
      type_q      <= BYTE;
      off_q       <= '0;
      sext_q      <= 1'b0;
      we_q        <= 1'b0;
      starve_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (if_gnt_o)
        starve_q <= '0;
      else if (dm_gnt_o && if_req_i && starve_q != 4'hF)
        starve_q <= starve_q + 4'd1;

      if (if_gnt_o) begin
        owner_q     <= OWNER_IF;
        type_q      <= WORD;
        off_q       <= if_addr_i[1:0];
        sext_q      <= 1'b0;
        we_q        <= 1'b0;
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_be_o    <= 4'b1111;
        mem_addr_o  <= {if_addr_i[WORD_SIZE-1:2], 2'b00};
        mem_wdata_o <= '0;
      end else if (dm_gnt_o) begin
        owner_q <= OWNER_DM;
        type_q  <= dm_type_i;
        off_q   <= dm_addr_i[1:0];
        sext_q  <= dm_sign_ext_i;
        we_q    <= dm_we_i;
        if (!dm_mis) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= dm_we_i;
          mem_be_o    <= store_be(dm_type_i, dm_addr_i[1:0]);
          mem_addr_o  <= {dm_addr_i[WORD_SIZE-1:2], 2'b00};
          mem_wdata_o <= dm_we_i ? store_data(dm_type_i, dm_wdata_i) : '0;
        end
      end else if (done) begin
        mem_req_o   <= 1'b0;
        mem_we_o    <= 1'b0;
        mem_be_o    <= '0;
        mem_addr_o  <= '0;
        mem_wdata_o <= '0;
      end
    end
  end

  segre_load_align u_load_align (
    .raw_i      (mem_rdata_i),
    .off_i      (off_q),
    .type_i     (type_q),
    .sign_ext_i (sext_q),
    .data_o     (load_data)
  );

  always_comb begin
    if_rvalid_o   = done && owner_q == OWNER_IF;
    if_rdata_o    = if_rvalid_o ? mem_rdata_i : '0;
    dm_misalign_o = state_q == ARB_MISALIGN;
    dm_rvalid_o   = (done && owner_q == OWNER_DM) || dm_misalign_o;
    dm_rdata_o    = (done && owner_q == OWNER_DM && !we_q) ? load_data : '0;
  end

endmodule
